// File: rtl/core_data_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core and the
// image DMA. Requests pass through combinationally; in-order responses are
// steered back to their issuer by a 1-bit ID FIFO.
module core_data_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  // core request/response
  input  logic                                  core_q_valid_i,
  output logic                                  core_q_ready_o,
  input  logic [AddrWidth-1:0]                  core_q_addr_i,
  input  logic                                  core_q_write_i,
  input  logic [DataWidth-1:0]                  core_q_data_i,
  input  logic [DataWidth/8-1:0]                core_q_strb_i,
  output logic                                  core_p_valid_o,
  output logic [DataWidth-1:0]                  core_p_data_o,
  output logic                                  core_p_error_o,
  // dma request/response
  input  logic                                  dma_q_valid_i,
  output logic                                  dma_q_ready_o,
  input  logic [AddrWidth-1:0]                  dma_q_addr_i,
  input  logic                                  dma_q_write_i,
  input  logic [DataWidth-1:0]                  dma_q_data_i,
  input  logic [DataWidth/8-1:0]                dma_q_strb_i,
  output logic                                  dma_p_valid_o,
  output logic [DataWidth-1:0]                  dma_p_data_o,
  output logic                                  dma_p_error_o,
  // memory side
  output logic                                  mem_q_valid_o,
  input  logic                                  mem_q_ready_i,
  output logic [AddrWidth-1:0]                  mem_q_addr_o,
  output logic                                  mem_q_write_o,
  output logic [DataWidth-1:0]                  mem_q_data_o,
  output logic [DataWidth/8-1:0]                mem_q_strb_o,
  input  logic                                  mem_p_valid_i,
  input  logic [DataWidth-1:0]                  mem_p_data_i,
  input  logic                                  mem_p_error_i,
  // status
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  spurious_rsp_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxOutstanding - 1);

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_e;

  req_id_e                   rr_q;
  logic                      lock_q;
  req_id_e                   lock_id_q;
  logic [MaxOutstanding-1:0] fifo_q;
  logic [PtrWidth-1:0]       wr_ptr_q;
  logic [PtrWidth-1:0]       rd_ptr_q;
  logic [CntWidth-1:0]       count_q;
  logic                      spurious_q;

  req_id_e gnt;
  logic    full;
  logic    gnt_valid;
  logic    push;
  logic    pop;
  req_id_e head;

  // Grant selection: a held lock wins, then a lone requester, then round-robin.
  always_comb begin
    gnt = REQ_CORE;
    if (lock_q) begin
      gnt = lock_id_q;
    end else if (core_q_valid_i && dma_q_valid_i) begin
      gnt = (rr_q == REQ_CORE) ? REQ_DMA : REQ_CORE;
    end else if (dma_q_valid_i) begin
      gnt = REQ_DMA;
    end
  end

  // Full blocking uses the pre-pop count, so a freed slot is reusable next cycle.
  assign full      = (count_q == CntMax);
  assign gnt_valid = (gnt == REQ_DMA) ? dma_q_valid_i : core_q_valid_i;

  assign mem_q_valid_o  = !rst_i && !full && gnt_valid;
  assign core_q_ready_o = !rst_i && !full && (gnt == REQ_CORE) && mem_q_ready_i;
  assign dma_q_ready_o  = !rst_i && !full && (gnt == REQ_DMA)  && mem_q_ready_i;

  // Forward the granted requester's fields to the memory port.
  always_comb begin
    mem_q_addr_o  = core_q_addr_i;
    mem_q_write_o = core_q_write_i;
    mem_q_data_o  = core_q_data_i;
    mem_q_strb_o  = core_q_strb_i;
    if (gnt == REQ_DMA) begin
      mem_q_addr_o  = dma_q_addr_i;
      mem_q_write_o = dma_q_write_i;
      mem_q_data_o  = dma_q_data_i;
      mem_q_strb_o  = dma_q_strb_i;
    end
  end

  assign push = mem_q_valid_o && mem_q_ready_i;
  assign pop  = !rst_i && mem_p_valid_i && (count_q != '0);
  assign head = req_id_e'(fifo_q[rd_ptr_q]);

  // Response routing: data fans out to both, only the head's issuer sees valid.
  assign core_p_valid_o = pop && (head == REQ_CORE);
  assign dma_p_valid_o  = pop && (head == REQ_DMA);
  assign core_p_data_o  = mem_p_data_i;
  assign dma_p_data_o   = mem_p_data_i;
  assign core_p_error_o = mem_p_error_i;
  assign dma_p_error_o  = mem_p_error_i;

  assign outstanding_o  = count_q;
  assign spurious_rsp_o = spurious_q;

  // Control state: round-robin pointer, stall lock, FIFO pointers/count, sticky flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= REQ_DMA;
      lock_q     <= 1'b0;
      lock_id_q  <= REQ_CORE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (push) begin
        rr_q     <= gnt;
        lock_q   <= 1'b0;
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrWidth'(1);
      end else if (mem_q_valid_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= gnt;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntWidth'(1);
      end
      if (mem_p_valid_i && (count_q == '0)) begin
        spurious_q <= 1'b1;
      end
    end
  end

  // ID FIFO storage: records which requester issued each accepted transaction.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= gnt;
    end
  end

endmodule

// File: tb/tb_core_data_arbiter.sv
// Directed bench for core_data_arbiter: single read, contention fairness,
// stall lock, full blocking, simultaneous push/pop and reset/spurious.
module tb_core_data_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_q_valid, core_q_ready, core_q_write;
  logic [31:0] core_q_addr, core_q_data;
  logic [3:0]  core_q_strb;
  logic        core_p_valid, core_p_error;
  logic [31:0] core_p_data;
  logic        dma_q_valid, dma_q_ready, dma_q_write;
  logic [31:0] dma_q_addr, dma_q_data;
  logic [3:0]  dma_q_strb;
  logic        dma_p_valid, dma_p_error;
  logic [31:0] dma_p_data;
  logic        mem_q_valid, mem_q_ready, mem_q_write;
  logic [31:0] mem_q_addr, mem_q_data;
  logic [3:0]  mem_q_strb;
  logic        mem_p_valid, mem_p_error;
  logic [31:0] mem_p_data;
  logic [1:0]  outstanding;
  logic        spurious;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_data_arbiter #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_q_valid_i(core_q_valid), .core_q_ready_o(core_q_ready),
    .core_q_addr_i(core_q_addr), .core_q_write_i(core_q_write),
    .core_q_data_i(core_q_data), .core_q_strb_i(core_q_strb),
    .core_p_valid_o(core_p_valid), .core_p_data_o(core_p_data), .core_p_error_o(core_p_error),
    .dma_q_valid_i(dma_q_valid), .dma_q_ready_o(dma_q_ready),
    .dma_q_addr_i(dma_q_addr), .dma_q_write_i(dma_q_write),
    .dma_q_data_i(dma_q_data), .dma_q_strb_i(dma_q_strb),
    .dma_p_valid_o(dma_p_valid), .dma_p_data_o(dma_p_data), .dma_p_error_o(dma_p_error),
    .mem_q_valid_o(mem_q_valid), .mem_q_ready_i(mem_q_ready),
    .mem_q_addr_o(mem_q_addr), .mem_q_write_o(mem_q_write),
    .mem_q_data_o(mem_q_data), .mem_q_strb_o(mem_q_strb),
    .mem_p_valid_i(mem_p_valid), .mem_p_data_i(mem_p_data), .mem_p_error_i(mem_p_error),
    .outstanding_o(outstanding), .spurious_rsp_o(spurious)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    core_q_valid = 1'b0; core_q_write = 1'b0; core_q_addr = 32'h0;
    core_q_data = 32'h0; core_q_strb = 4'h0;
    dma_q_valid = 1'b0; dma_q_write = 1'b0; dma_q_addr = 32'h0;
    dma_q_data = 32'h0; dma_q_strb = 4'h0;
    mem_q_ready = 1'b0; mem_p_valid = 1'b0; mem_p_data = 32'h0; mem_p_error = 1'b0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // reset: outputs forced low even with an active request
    next_cycle();
    core_q_valid = 1'b1; core_q_addr = 32'h40; mem_q_ready = 1'b1;
    sample();
    check_eq("rst_mem_valid", mem_q_valid, 0);
    check_eq("rst_core_ready", core_q_ready, 0);
    next_cycle();
    rst = 1'b0;
    sample();
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_spurious", spurious, 0);

    // single core read
    next_cycle();
    core_q_valid = 1'b1; core_q_addr = 32'h100; mem_q_ready = 1'b1;
    sample();
    check_eq("rd_mem_valid", mem_q_valid, 1);
    check_eq("rd_mem_addr", mem_q_addr, 32'h100);
    check_eq("rd_core_ready", core_q_ready, 1);
    check_eq("rd_dma_ready", dma_q_ready, 0);
    check_eq("rd_outst0", outstanding, 0);
    next_cycle();
    mem_p_valid = 1'b1; mem_p_data = 32'hCAFE_F00D;
    sample();
    check_eq("rd_outst1", outstanding, 1);
    check_eq("rd_core_pvalid", core_p_valid, 1);
    check_eq("rd_core_pdata", core_p_data, 32'hCAFE_F00D);
    check_eq("rd_dma_pvalid", dma_p_valid, 0);
    next_cycle();
    sample();
    check_eq("rd_outst2", outstanding, 0);

    // contention fairness after a fresh reset (core wins the first tie)
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      core_q_valid = 1'b1; core_q_addr = 32'h200;
      dma_q_valid  = 1'b1; dma_q_addr  = 32'h300;
      mem_q_ready  = 1'b1;
      if (k > 0) begin
        mem_p_valid = 1'b1; mem_p_data = 32'h1000 + k;
      end
      sample();
      check_eq($sformatf("rr_addr%0d", k), mem_q_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
      check_eq($sformatf("rr_core_rdy%0d", k), core_q_ready, (k % 2 == 0) ? 1 : 0);
      check_eq($sformatf("rr_outst%0d", k), outstanding, (k == 0) ? 0 : 1);
      if (k > 0) begin
        check_eq($sformatf("rr_core_pv%0d", k), core_p_valid, ((k - 1) % 2 == 0) ? 1 : 0);
        check_eq($sformatf("rr_dma_pv%0d", k), dma_p_valid, ((k - 1) % 2 == 1) ? 1 : 0);
      end
    end
    next_cycle();
    mem_p_valid = 1'b1; mem_p_data = 32'h2000;
    sample();
    check_eq("rr_last_dma_pv", dma_p_valid, 1);
    check_eq("rr_last_dma_pdata", dma_p_data, 32'h2000);
    next_cycle();
    sample();
    check_eq("rr_drained", outstanding, 0);

    // stall lock: make rr point at core so that an unlocked tie would pick dma
    next_cycle();
    core_q_valid = 1'b1; core_q_write = 1'b1; core_q_addr = 32'h400;
    core_q_data = 32'h55; core_q_strb = 4'hF; mem_q_ready = 1'b1;
    sample();
    check_eq("wr_mem_write", mem_q_write, 1);
    check_eq("wr_mem_strb", mem_q_strb, 4'hF);
    next_cycle();
    mem_p_valid = 1'b1; mem_p_error = 1'b1;
    sample();
    check_eq("wr_core_perr", core_p_error, 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      core_q_valid = 1'b1; core_q_addr = 32'h200;
      dma_q_valid  = (k > 0); dma_q_addr = 32'h300;
      sample();
      check_eq($sformatf("stall_addr%0d", k), mem_q_addr, 32'h200);
      check_eq($sformatf("stall_valid%0d", k), mem_q_valid, 1);
      check_eq($sformatf("stall_dma_rdy%0d", k), dma_q_ready, 0);
    end
    next_cycle();
    core_q_valid = 1'b1; core_q_addr = 32'h200;
    dma_q_valid = 1'b1; dma_q_addr = 32'h300; mem_q_ready = 1'b1;
    sample();
    check_eq("stall_hs_addr", mem_q_addr, 32'h200);
    check_eq("stall_hs_core_rdy", core_q_ready, 1);
    // dma granted next, with core's response in the same cycle (push+pop at 1)
    next_cycle();
    dma_q_valid = 1'b1; dma_q_addr = 32'h300; mem_q_ready = 1'b1;
    mem_p_valid = 1'b1; mem_p_data = 32'h3000;
    sample();
    check_eq("pp_dma_addr", mem_q_addr, 32'h300);
    check_eq("pp_dma_rdy", dma_q_ready, 1);
    check_eq("pp_core_pv", core_p_valid, 1);
    check_eq("pp_outst", outstanding, 1);
    next_cycle();
    mem_p_valid = 1'b1;
    sample();
    check_eq("pp_outst_kept", outstanding, 1);
    check_eq("pp_dma_pv", dma_p_valid, 1);
    next_cycle();
    sample();
    check_eq("pp_drained", outstanding, 0);

    // full blocking with MaxOutstanding=2
    next_cycle();
    core_q_valid = 1'b1; core_q_addr = 32'h500; mem_q_ready = 1'b1;
    next_cycle();
    dma_q_valid = 1'b1; dma_q_addr = 32'h600; mem_q_ready = 1'b1;
    sample();
    check_eq("full_dma_rdy", dma_q_ready, 1);
    next_cycle();
    core_q_valid = 1'b1; core_q_addr = 32'h700; mem_q_ready = 1'b1;
    sample();
    check_eq("full_outst2", outstanding, 2);
    check_eq("full_mem_valid", mem_q_valid, 0);
    check_eq("full_core_rdy", core_q_ready, 0);
    next_cycle();
    core_q_valid = 1'b1; core_q_addr = 32'h700; mem_q_ready = 1'b1; mem_p_valid = 1'b1;
    sample();
    check_eq("full_pop_mem_valid", mem_q_valid, 0);
    check_eq("full_pop_core_pv", core_p_valid, 1);
    next_cycle();
    core_q_valid = 1'b1; core_q_addr = 32'h700; mem_q_ready = 1'b1;
    sample();
    check_eq("full_accept_valid", mem_q_valid, 1);
    check_eq("full_accept_rdy", core_q_ready, 1);
    check_eq("full_accept_outst", outstanding, 1);
    next_cycle();
    sample();
    check_eq("full_again", outstanding, 2);

    // reset mid-flight, then a late response is flagged spurious
    next_cycle();
    rst = 1'b1; core_q_valid = 1'b1; mem_q_ready = 1'b1; mem_p_valid = 1'b1;
    sample();
    check_eq("mid_rst_mem_valid", mem_q_valid, 0);
    check_eq("mid_rst_core_rdy", core_q_ready, 0);
    check_eq("mid_rst_core_pv", core_p_valid, 0);
    check_eq("mid_rst_dma_pv", dma_p_valid, 0);
    next_cycle();
    rst = 1'b0; mem_p_valid = 1'b1;
    sample();
    check_eq("spur_outst", outstanding, 0);
    check_eq("spur_core_pv", core_p_valid, 0);
    check_eq("spur_dma_pv", dma_p_valid, 0);
    check_eq("spur_not_yet", spurious, 0);
    next_cycle();
    sample();
    check_eq("spur_flag", spurious, 1);
    next_cycle();
    sample();
    check_eq("spur_sticky", spurious, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
